// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and latency constants.
package muldiv_pkg;

    localparam int MULDIV_ITERS = 32;
    localparam int MULDIV_LAT   = 34;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Write_hi;
    logic [WIDTH-1:0] Write_lo;

    modport master (
        output start, op, a, b, mthi, mtlo, cancel,
        input  busy, done, Write_hi, Write_lo
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo, cancel,
        output busy, done, Write_hi, Write_lo
    );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide
// step, chosen by div_mode_i. {hi_i, lo_i} is the working accumulator.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             div_mode_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        sum    = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
        rem_sh = {hi_i, lo_i[WIDTH-1]};
        ge     = (rem_sh >= {1'b0, opnd_i});
        // When ge holds the true difference is below the divisor, so the
        // low WIDTH bits of the subtraction are exact.
        diff   = rem_sh[WIDTH-1:0] - opnd_i;
        if (div_mode_i) begin
            hi_o = ge ? diff : rem_sh[WIDTH-1:0];
            lo_o = {lo_i[WIDTH-2:0], ge};
        end else begin
            hi_o = sum[WIDTH:1];
            lo_o = {sum[0], lo_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with MTHI/MTLO, producing the HI/LO
// write buses. Fixed latency: done pulses 34 edges after start is sampled.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fix2_q, fix2_d;
    logic             div_q, div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div0_q, div0_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] whi_q, whi_d;
    logic [WIDTH-1:0] wlo_q, wlo_d;
    logic             done_q, done_d;

    op_e              op_s;
    logic             sgn_op;
    logic             div_op;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [2*WIDTH-1:0] prod_neg;

    assign op_s     = op_e'(bus.op);
    assign sgn_op   = op_is_signed(op_s);
    assign div_op   = op_is_div(op_s);
    assign a_mag    = (sgn_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_mag    = (sgn_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    assign prod_neg = -{hi_q, lo_q};

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_mode_i (div_q),
        .hi_i       (hi_q),
        .lo_i       (lo_q),
        .opnd_i     (opnd_q),
        .hi_o       (step_hi),
        .lo_o       (step_lo)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fix2_d    = fix2_q;
        div_d     = div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        whi_d     = whi_q;
        wlo_d     = wlo_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (!bus.cancel) begin
                        state_d   = CALC;
                        cnt_d     = '0;
                        fix2_d    = 1'b0;
                        div_d     = div_op;
                        opnd_d    = div_op ? b_mag : a_mag;
                        hi_d      = '0;
                        lo_d      = div_op ? a_mag : b_mag;
                        neg_res_d = sgn_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_rem_d = sgn_op & bus.a[WIDTH-1];
                        div0_d    = div_op & (bus.b == '0);
                    end
                end else begin
                    if (bus.mthi) whi_d = bus.a;
                    if (bus.mtlo) wlo_d = bus.a;
                end
            end
            CALC: begin
                if (bus.cancel) begin
                    state_d = IDLE;
                end else begin
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
                end
            end
            FIX: begin
                // First FIX cycle applies the sign fixup, second publishes it.
                if (bus.cancel) begin
                    state_d = IDLE;
                end else if (!fix2_q) begin
                    fix2_d = 1'b1;
                    if (div_q) begin
                        lo_d = div0_q ? '1 : (neg_res_q ? -lo_q : lo_q);
                        hi_d = neg_rem_q ? -hi_q : hi_q;
                    end else if (neg_res_q) begin
                        {hi_d, lo_d} = prod_neg;
                    end
                end else begin
                    whi_d   = hi_q;
                    wlo_d   = lo_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            fix2_q    <= 1'b0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            whi_q     <= '0;
            wlo_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fix2_q    <= fix2_d;
            div_q     <= div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            whi_q     <= whi_d;
            wlo_q     <= wlo_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.Write_hi = whi_q;
    assign bus.Write_lo = wlo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: latency, results, moves, cancel
// and asynchronous reset.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    muldiv_if #(.WIDTH(32)) mif ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mif.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_move(input string tag, input logic hi_v, input logic lo_v,
                           input logic [31:0] data, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo);
        @(negedge clk);
        mif.a    = data;
        mif.mthi = hi_v;
        mif.mtlo = lo_v;
        @(posedge clk); #1;
        mif.mthi = 1'b0;
        mif.mtlo = 1'b0;
        check({tag, "_hi"}, mif.Write_hi, exp_hi);
        check({tag, "_lo"}, mif.Write_lo, exp_lo);
        check({tag, "_done"}, 32'(mif.done), 32'd0);
        check({tag, "_busy"}, 32'(mif.busy), 32'd0);
        $display("move %s: hi=0x%08h lo=0x%08h", tag, mif.Write_hi, mif.Write_lo);
    endtask

    // Issues one op; injection cycles of -1 disable the corresponding stray input.
    task automatic run_op(input string tag, input logic [1:0] op_v,
                          input logic [31:0] a_v, input logic [31:0] b_v,
                          input bit move_at_start, input int start_inj,
                          input int mthi_inj, input int cancel_inj,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int k;
        int done_at;
        logic [31:0] prev_hi;
        prev_hi = mif.Write_hi;
        @(negedge clk);
        mif.op    = op_v;
        mif.a     = a_v;
        mif.b     = b_v;
        mif.start = 1'b1;
        mif.mthi  = move_at_start;
        @(posedge clk); #1;
        mif.start = 1'b0;
        mif.mthi  = 1'b0;
        check({tag, "_busy"}, 32'(mif.busy), 32'd1);
        check({tag, "_done_low"}, 32'(mif.done), 32'd0);
        if (move_at_start) check({tag, "_start_wins"}, mif.Write_hi, prev_hi);
        k = 0;
        done_at = 0;
        while (k < 45 && done_at == 0) begin
            mif.start  = (k == start_inj);
            if (k == start_inj) begin
                mif.op = OP_MULTU;
                mif.a  = 32'h0000_0011;
                mif.b  = 32'h0000_0003;
            end
            mif.mthi   = (k == mthi_inj);
            if (k == mthi_inj) mif.a = 32'hDEAD_BEEF;
            mif.cancel = (k == cancel_inj);
            @(posedge clk); #1;
            k++;
            mif.start  = 1'b0;
            mif.mthi   = 1'b0;
            mif.cancel = 1'b0;
            if (k == mthi_inj + 1) check({tag, "_mthi_ignored"}, mif.Write_hi, prev_hi);
            if (k == cancel_inj + 1) check({tag, "_cancel_busy"}, 32'(mif.busy), 32'd0);
            if (mif.done) done_at = k;
        end
        if (cancel_inj >= 0) begin
            check({tag, "_no_done"}, 32'(done_at), 32'd0);
        end else begin
            check({tag, "_latency"}, 32'(done_at), 32'(MULDIV_LAT));
        end
        check({tag, "_busy_end"}, 32'(mif.busy), 32'd0);
        check({tag, "_hi"}, mif.Write_hi, exp_hi);
        check({tag, "_lo"}, mif.Write_lo, exp_lo);
        $display("op %s: op=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h done_at=%0d",
                 tag, op_v, a_v, b_v, mif.Write_hi, mif.Write_lo, done_at);
    endtask

    initial begin
        rst_n      = 1'b0;
        mif.start  = 1'b0;
        mif.op     = 2'b00;
        mif.a      = '0;
        mif.b      = '0;
        mif.mthi   = 1'b0;
        mif.mtlo   = 1'b0;
        mif.cancel = 1'b0;
        #12;
        check("rst_busy", 32'(mif.busy), 32'd0);
        check("rst_done", 32'(mif.done), 32'd0);
        check("rst_hi", mif.Write_hi, 32'd0);
        check("rst_lo", mif.Write_lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_move("mthi", 1'b1, 1'b0, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000);
        do_move("mtlo", 1'b0, 1'b1, 32'h0000_ABCD, 32'h0000_1234, 32'h0000_ABCD);
        do_move("mtboth", 1'b1, 1'b1, 32'h0000_0055, 32'h0000_0055, 32'h0000_0055);

        run_op("mult_m1x2",  OP_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 1'b0, -1, -1, -1,
               32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu_x2",   OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, -1, -1, -1,
               32'h0000_0001, 32'hFFFF_FFFE);
        run_op("mult_m3x5",  OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 1'b0, -1, -1, -1,
               32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("div_m7d2",   OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 1'b0, -1, -1, -1,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_7d2",   OP_DIVU,  32'h0000_0007, 32'h0000_0002, 1'b1, -1, -1, -1,
               32'h0000_0001, 32'h0000_0003);
        run_op("div_7dm2",   OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 1'b0, -1, -1, -1,
               32'h0000_0001, 32'hFFFF_FFFD);
        run_op("divu_5d0",   OP_DIVU,  32'h0000_0005, 32'h0000_0000, 1'b0, -1, -1, -1,
               32'h0000_0005, 32'hFFFF_FFFF);
        run_op("div_m5d0",   OP_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 1'b0, -1, -1, -1,
               32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_op("div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1, -1, -1,
               32'h0000_0000, 32'h8000_0000);
        run_op("div_inject", OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 5, 6, -1,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_cancel", OP_DIV,   32'h0000_0064, 32'h0000_0007, 1'b0, -1, -1, 10,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        mif.op    = OP_MULTU;
        mif.a     = 32'h0000_0009;
        mif.b     = 32'h0000_0009;
        mif.start = 1'b1;
        @(posedge clk); #1;
        mif.start = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        check("midrst_busy_before", 32'(mif.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(mif.busy), 32'd0);
        check("midrst_done", 32'(mif.done), 32'd0);
        check("midrst_hi", mif.Write_hi, 32'd0);
        check("midrst_lo", mif.Write_lo, 32'd0);
        $display("reset mid-CALC: busy=%0d hi=0x%08h lo=0x%08h", mif.busy, mif.Write_hi, mif.Write_lo);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("multu_3x4", OP_MULTU, 32'h0000_0003, 32'h0000_0004, 1'b0, -1, -1, -1,
               32'h0000_0000, 32'h0000_000C);
        @(posedge clk); #1;
        check("done_pulse_end", 32'(mif.done), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the dynamic pipeline. It sits in the execute stage and is the producer side of the HI/LO register pair. It executes MULT, MULTU, DIV and DIVU over a fixed 34-cycle latency and also handles MTHI and MTLO. It drives the HI and LO write buses continuously, so the HI/LO storage captures a stable value on every clock.

## Interface
Parameters:
- `WIDTH`, default 32: operand width and HI/LO width.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request an operation; sampled only in IDLE.
- `op`  in  2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  WIDTH: multiplicand / dividend; also the data for MTHI/MTLO.
- `b`  in  WIDTH: multiplier / divisor.
- `mthi`  in  1: load HI from `a`; honoured only in IDLE.
- `mtlo`  in  1: load LO from `a`; honoured only in IDLE.
- `cancel`  in  1: pipeline flush; aborts the operation in flight.
- `busy`  out  1: operation in flight; the pipeline stalls HI/LO consumers while high.
- `done`  out  1: one-cycle pulse; new HI/LO are visible in this cycle.
- `Write_hi`  out  WIDTH: registered HI value, held between updates.
- `Write_lo`  out  WIDTH: registered LO value, held between updates.

## Operation
- FSM states:
  - IDLE: `start` goes to CALC; operands latched.
  - CALC: 32 iterations, then FIX.
  - FIX: sign fixup; writes `Write_hi`/`Write_lo`, pulses `done`, returns to IDLE.
- Signed ops work on magnitudes; signs are recorded at start.
- Multiply:
  - Shift-add, one bit per cycle.
  - 64-bit product: HI = upper word, LO = lower word.
  - Product is negated in FIX when the operand signs differ (MULT only).
- Divide:
  - Restoring division, one quotient bit per cycle.
  - LO = quotient, HI = remainder.
  - Quotient is negative when the signs differ; the remainder takes the dividend's sign.
- Divide by zero (DIV and DIVU): HI = `a`, LO = all ones.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- MTHI/MTLO in IDLE:
  - Update the selected register at the next edge; the other register is unchanged.
  - No `done`, no `busy`.
  - If both are high, both registers load `a`.
- `start` together with `mthi`/`mtlo` in IDLE: `start` wins; the moves are dropped.
- `start`, `mthi` and `mtlo` are ignored outside IDLE.
- `cancel`:
  - In CALC or FIX, go to IDLE at the next edge.
  - `Write_hi`/`Write_lo` unchanged, no `done`.
  - A `cancel` in the same cycle as `start` in IDLE suppresses the start.
- Reset (asynchronous):
  - Values: state IDLE, `busy`=0, `done`=0, `Write_hi`=0, `Write_lo`=0.
  - Effective immediately, including mid-CALC; any partial result is discarded.

## Timing
- `start` sampled high at edge N: CALC occupies edges N+1..N+32, FIX at edge N+33.
- Edge N+34 pulses `done` and updates `Write_hi`/`Write_lo`.
- `busy` is high after edge N through edge N+33 and low in the `done` cycle.
- A new `start` is accepted in the `done` cycle, giving back-to-back operations every 35 cycles.
- Latency is identical for all four ops, including divide by zero.
- Outputs are registers and are stable for the whole cycle, so a downstream capture on either clock edge is safe.
- MTHI/MTLO: `Write_hi`/`Write_lo` change at the edge after sampling, a latency of 1.

## Structure
- Shared package `muldiv_pkg`:
  - Op encodings `OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`.
  - FSM state enum (IDLE, CALC, FIX).
  - `MULDIV_ITERS` = 32.
  - `MULDIV_LAT` = 34.
- One sub-module, `muldiv_step`: the combinational single-iteration datapath (shift-add step or restoring subtract step, selected by a mode bit).
- The top level holds the FSM, the iteration counter, the operand, accumulator and sign registers, the fixup logic and the output registers.

## Test plan
- MULT a=0xFFFFFFFF b=2 -> `done` 34 cycles after start; HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=7, b=2 -> LO=3, HI=1.
- DIVU a=5, b=0 -> HI=5, LO=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0. Both with the same 34-cycle latency.
- Start a DIV; pulse `start` with different operands at cycle 5 and `mthi` at cycle 6 -> both ignored, first result only. Repeat with `cancel` at cycle 10 -> `busy` low at the next edge, HI/LO keep their prior values, no `done`.
- Deassert `rst_n` mid-CALC (cycle 17) -> `busy`, `done`, `Write_hi`, `Write_lo` go to 0 without waiting for a clock edge. After release, a fresh MULTU 3×4 -> LO=12, HI=0.
- MTHI a=0x1234 in IDLE -> `Write_hi`=0x1234 after one edge, LO unchanged, `done` stays 0. MTLO a=0xABCD -> `Write_lo`=0xABCD.
